// File: rtl/ram_nxm.sv
// ram_nxm: single-port DEPTH x WIDTH RAM with request/acknowledge handshake.
// After clr deasserts, a sweep writes zero to every word, one per clock,
// before any request is accepted. Out-of-range addresses are acknowledged
// with err so a requester never waits for a response that cannot come.
module ram_nxm #(
    parameter  int WIDTH = 4,
    parameter  int DEPTH = 16,
    localparam int AW    = (DEPTH > 2) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             req,
    input  logic             rw,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             ack,
    output logic             err,
    output logic             busy
);

    // Extended by one bit so DEPTH itself is representable in the compare.
    localparam logic [AW:0]   DEPTH_X = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

    typedef enum logic {
        SWEEP,
        IDLE
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [AW-1:0]    cnt;
    logic [AW-1:0]    cnt_next;
    logic [WIDTH-1:0] mem [DEPTH];

    logic             in_range;
    logic             mem_we;
    logic [AW-1:0]    mem_waddr;
    logic [WIDTH-1:0] mem_wdata;
    logic             load_dout;
    logic [WIDTH-1:0] dout_next;
    logic             ack_next;
    logic             err_next;

    assign in_range = ({1'b0, addr} < DEPTH_X);
    assign busy     = (state == SWEEP);

    // State register; clr always restarts the clear sweep.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state <= SWEEP;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and datapath control: the sweep owns the write port, and
    // in IDLE the request decides write, read or an err response.
    always_comb begin
        next_state = state;
        cnt_next   = cnt;
        mem_we     = 1'b0;
        mem_waddr  = cnt;
        mem_wdata  = '0;
        load_dout  = 1'b0;
        dout_next  = '0;
        ack_next   = 1'b0;
        err_next   = 1'b0;
        case (state)
            SWEEP: begin
                mem_we    = 1'b1;
                mem_waddr = cnt;
                mem_wdata = '0;
                if (cnt == LAST) begin
                    next_state = IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + AW'(1);
                end
            end
            IDLE: begin
                if (req) begin
                    ack_next = 1'b1;
                    err_next = !in_range;
                    if (rw) begin
                        if (in_range) begin
                            mem_we    = 1'b1;
                            mem_waddr = addr;
                            mem_wdata = data_in;
                        end
                    end else begin
                        load_dout = 1'b1;
                        dout_next = in_range ? mem[addr] : '0;
                    end
                end
            end
            default: begin
                next_state = SWEEP;
                cnt_next   = '0;
            end
        endcase
    end

    // Sweep counter, read data and response flags; all cleared by clr.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            cnt      <= '0;
            data_out <= '0;
            ack      <= 1'b0;
            err      <= 1'b0;
        end else begin
            cnt <= cnt_next;
            ack <= ack_next;
            err <= err_next;
            if (load_dout) begin
                data_out <= dout_next;
            end
        end
    end

    // Storage array has no reset; it is zeroed only by the sweep, and no
    // write may land while clr is held.
    always_ff @(posedge clk) begin
        if (!clr && mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

endmodule

// File: tb/tb_ram_nxm.sv
// tb_ram_nxm: scoreboard bench for ram_nxm. A reference model predicts each
// response when a request is sampled; a monitor compares on every cycle.
module tb_ram_nxm;

    localparam int WIDTH = 4;
    localparam int DEPTH = 12;
    localparam int AW    = (DEPTH > 2) ? $clog2(DEPTH) : 1;

    logic             clk;
    logic             clr;
    logic             req;
    logic             rw;
    logic [AW-1:0]    addr;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] data_out;
    logic             ack;
    logic             err;
    logic             busy;

    int checks   = 0;
    int failures = 0;

    ram_nxm #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) dut (
        .clk     (clk),
        .clr     (clr),
        .req     (req),
        .rw      (rw),
        .addr    (addr),
        .data_in (data_in),
        .data_out(data_out),
        .ack     (ack),
        .err     (err),
        .busy    (busy)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int               cyc;
        logic             err;
        logic [WIDTH-1:0] dout;
    } exp_t;

    exp_t             exp_q[$];
    exp_t             got;
    logic [WIDTH-1:0] model_mem [DEPTH];
    logic [WIDTH-1:0] model_dout = '0;
    int               sweep_left = DEPTH;
    int               cyc        = 0;
    logic             mon_en     = 1'b0;
    logic             model_busy;

    assign model_busy = clr || (sweep_left > 0);

    task automatic check_output(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t",
                     name, act, exp, $time);
        end
    endtask

    // Reset in the model: pending responses vanish and the clear restarts.
    always @(posedge clr) begin
        exp_q.delete();
        sweep_left = DEPTH;
        model_dout = '0;
    end

    // Reference model: a clear takes DEPTH edges, then every request is
    // answered on the next cycle; predictions go into the scoreboard queue.
    always @(posedge clk) begin
        exp_t e;
        cyc++;
        if (!clr) begin
            if (sweep_left > 0) begin
                sweep_left--;
                if (sweep_left == 0) begin
                    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
                end
            end else if (req) begin
                e.cyc = cyc;
                e.err = (int'(addr) >= DEPTH);
                if (rw) begin
                    if (!e.err) model_mem[addr] = data_in;
                end else begin
                    model_dout = e.err ? '0 : model_mem[addr];
                end
                e.dout = model_dout;
                exp_q.push_back(e);
            end
        end
    end

    // Monitor: away from the active edge, compare outputs to the scoreboard.
    always @(negedge clk) begin
        if (mon_en) begin
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                check_output("ack_missing", 32'(ack), 32'(1));
                void'(exp_q.pop_front());
            end
            check_output("busy", 32'(busy), 32'(model_busy));
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                got = exp_q.pop_front();
                check_output("ack", 32'(ack), 32'(1));
                check_output("err", 32'(err), 32'(got.err));
                check_output("rdata", 32'(data_out), 32'(got.dout));
            end else begin
                check_output("ack_idle", 32'(ack), 32'(0));
                check_output("err_idle", 32'(err), 32'(0));
            end
            check_output("dout_hold", 32'(data_out), 32'(model_dout));
        end
    end

    // Drive one cycle of request inputs just after a rising edge.
    task automatic apply_stimulus(input logic r, input logic w,
                                  input logic [AW-1:0] a,
                                  input logic [WIDTH-1:0] d);
        @(posedge clk);
        #1;
        req     = r;
        rw      = w;
        addr    = a;
        data_in = d;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) apply_stimulus(1'b0, 1'b0, '0, '0);
    endtask

    task automatic random_traffic(input int n);
        for (int i = 0; i < n; i++) begin
            apply_stimulus(($urandom_range(0, 3) != 0), 1'(($urandom_range(0, 1))),
                           AW'($urandom_range(0, (1 << AW) - 1)),
                           WIDTH'($urandom));
        end
    endtask

    // Immediate effect of clr, checked between edges.
    task automatic check_reset_now(input string tag);
        #1;
        check_output({tag, "_busy"}, 32'(busy), 32'(1));
        check_output({tag, "_ack"}, 32'(ack), 32'(0));
        check_output({tag, "_err"}, 32'(err), 32'(0));
        check_output({tag, "_dout"}, 32'(data_out), 32'(0));
    endtask

    // Main stimulus sequence.
    initial begin
        clr     = 1'b0;
        req     = 1'b0;
        rw      = 1'b0;
        addr    = '0;
        data_in = '0;
        #1;
        clr = 1'b1;
        check_reset_now("por");
        mon_en = 1'b1;

        // Requests held during reset and the sweep must all be ignored.
        apply_stimulus(1'b1, 1'b1, AW'(4), WIDTH'(4'h6));
        apply_stimulus(1'b1, 1'b1, AW'(1), WIDTH'(4'h3));
        clr = 1'b0;
        for (int i = 0; i < DEPTH - 1; i++) begin
            apply_stimulus(1'b1, 1'b1, AW'(i % DEPTH), WIDTH'($urandom));
        end
        for (int i = 0; i < DEPTH; i++) apply_stimulus(1'b1, 1'b0, AW'(i), '0);

        // Write then read back one word.
        apply_stimulus(1'b1, 1'b1, AW'(3), WIDTH'(4'hA));
        apply_stimulus(1'b1, 1'b0, AW'(3), '0);
        idle_cycles(1);

        // Back-to-back write/read/write/read on one address.
        apply_stimulus(1'b1, 1'b1, AW'(5), WIDTH'(4'h7));
        apply_stimulus(1'b1, 1'b0, AW'(5), '0);
        apply_stimulus(1'b1, 1'b1, AW'(5), WIDTH'(4'h2));
        apply_stimulus(1'b1, 1'b0, AW'(5), '0);

        // Out-of-range write and read, then confirm a neighbour is intact.
        apply_stimulus(1'b1, 1'b1, AW'(1), WIDTH'(4'h4));
        apply_stimulus(1'b1, 1'b1, AW'(13), WIDTH'(4'hF));
        apply_stimulus(1'b1, 1'b0, AW'(13), '0);
        apply_stimulus(1'b1, 1'b0, AW'(1), '0);
        apply_stimulus(1'b1, 1'b0, AW'(DEPTH - 1), '0);
        idle_cycles(2);

        random_traffic(300);

        // Abort an in-flight read, then abort a sweep part-way through.
        apply_stimulus(1'b1, 1'b1, AW'(2), WIDTH'(4'h9));
        apply_stimulus(1'b1, 1'b0, AW'(2), '0);
        apply_stimulus(1'b1, 1'b0, AW'(2), '0);
        apply_stimulus(1'b0, 1'b0, '0, '0);
        clr = 1'b1;
        check_reset_now("abort_access");
        idle_cycles(1);
        clr = 1'b0;
        idle_cycles(5);
        clr = 1'b1;
        check_reset_now("abort_sweep");
        idle_cycles(2);
        clr = 1'b0;
        idle_cycles(DEPTH);
        apply_stimulus(1'b1, 1'b0, AW'(2), '0);
        apply_stimulus(1'b1, 1'b0, AW'(3), '0);
        idle_cycles(1);

        random_traffic(300);
        idle_cycles(3);

        check_output("queue_drained", 32'(exp_q.size()), 32'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
